// File: rtl/tc_serial_ctrl.sv
// rtl/tc_serial_ctrl.sv - sequencing controller for the bit-serial two's-complement unit
//
// Purpose:
//   Takes a parallel W-bit word over a valid/ready handshake, streams it LSB-first
//   into the external bit-serial complementer (pulsing its reset with the LSB),
//   reassembles the returned serial bits and presents the result over a second
//   valid/ready handshake. One word in flight at a time.
//
// Optional build macro: TC_SERIAL_ABS_EN
//   Defined   : absolute value; non-negative inputs are streamed (same timing) but
//               the captured input is returned instead of the unit result.
//   Undefined : every word is negated.
//
// Ports:
//   t_clk      clock, rising edge
//   r          synchronous active-high reset
//   in_valid   input word valid
//   in_ready   controller idle, can accept a word (combinational from state)
//   in_data    W-bit word to process
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts result
//   out_data   W-bit result word
//   out_ovf    input was the most-negative value
//   ser_i      serial bit to unit, LSB first
//   ser_r      reset / first-bit marker to unit
//   ser_y      serial result bit from unit (Y_LAT cycles behind ser_i)
//   busy       high while shifting or draining
module tc_serial_ctrl #(
   parameter int W     = 8,
   parameter int Y_LAT = 0
) (
   input  logic         t_clk,
   input  logic         r,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_ovf,
   output logic         ser_i,
   output logic         ser_r,
   input  logic         ser_y,
   output logic         busy
);

   localparam int KW = $clog2(W);
   localparam int DW = (Y_LAT > 0) ? $clog2(Y_LAT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   logic [W-1:0]  r_sreg;   // remaining input bits; bit 0 is the next bit to send
   logic [W-1:0]  r_res;    // result assembled MSB-in, so first sample lands in bit 0
   logic [KW-1:0] r_k;      // bit index being driven on ser_i
   logic [KW-1:0] r_j;      // bit index being sampled from ser_y
   logic [DW-1:0] r_dly;    // cycles left before ser_y carries bit 0
   logic          r_ovf;
`ifdef TC_SERIAL_ABS_EN
   logic [W-1:0]  r_orig;
`endif

   logic          w_busy;
   logic          w_samp;
   logic          w_last;
   logic [W-1:0]  w_res_next;
   logic [W-1:0]  w_result;

   assign w_busy     = (r_state == S_SHIFT) || (r_state == S_DRAIN);
   // Sampling lags driving by Y_LAT cycles and may run on into DRAIN
   assign w_samp     = w_busy && (r_dly == '0);
   assign w_last     = w_samp && (r_j == KW'(W - 1));
   assign w_res_next = {ser_y, r_res[W-1:1]};

`ifdef TC_SERIAL_ABS_EN
   assign w_result = r_orig[W-1] ? w_res_next : r_orig;
`else
   assign w_result = w_res_next;
`endif

   assign in_ready = (r_state == S_IDLE);
   assign busy     = w_busy;

   always_ff @(posedge t_clk) begin
      if (r) begin
         r_state   <= S_IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
         ser_i     <= 1'b0;
         ser_r     <= 1'b1;
         r_sreg    <= '0;
         r_res     <= '0;
         r_k       <= '0;
         r_j       <= '0;
         r_dly     <= '0;
         r_ovf     <= 1'b0;
`ifdef TC_SERIAL_ABS_EN
         r_orig    <= '0;
`endif
      end else begin
         if (w_samp) begin
            r_res <= w_res_next;
            r_j   <= r_j + KW'(1);
         end
         if (w_busy && (r_dly != '0)) begin
            r_dly <= r_dly - DW'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  // ser_i is registered, so bit 0 goes out right away and the
                  // shift register holds the bits still to come
                  r_sreg  <= in_data >> 1;
                  ser_i   <= in_data[0];
                  ser_r   <= 1'b1;
                  r_ovf   <= (in_data == {1'b1, {(W-1){1'b0}}});
                  r_k     <= '0;
                  r_j     <= '0;
                  r_dly   <= DW'(Y_LAT);
                  r_state <= S_SHIFT;
`ifdef TC_SERIAL_ABS_EN
                  r_orig  <= in_data;
`endif
               end
            end
            S_SHIFT: begin
               r_sreg <= r_sreg >> 1;
               ser_i  <= r_sreg[0];
               ser_r  <= 1'b0;
               r_k    <= r_k + KW'(1);
               if (r_k == KW'(W - 1)) begin
                  ser_i   <= 1'b0;
                  r_state <= S_DRAIN;   // overridden below when no drain is needed
               end
            end
            S_DRAIN: begin
               ser_i <= 1'b0;
               ser_r <= 1'b0;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Final sample completes the word whether it falls in SHIFT or DRAIN
         if (w_last) begin
            out_data  <= w_result;
            out_ovf   <= r_ovf;
            out_valid <= 1'b1;
            ser_i     <= 1'b0;
            ser_r     <= 1'b1;
            r_state   <= S_DONE;
         end
      end
   end

endmodule

// File: tb/tb_tc_serial_ctrl.sv
// tb/tb_tc_serial_ctrl.sv - scoreboard bench for tc_serial_ctrl (Y_LAT=0 and Y_LAT=2 instances)
`timescale 1ns/1ps
module tb_tc_serial_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [1:0]      in_valid;
   logic [1:0][7:0] in_data;
   logic [1:0]      out_ready;
   logic [1:0]      in_ready;
   logic [1:0]      out_valid;
   logic [1:0][7:0] out_data;
   logic [1:0]      out_ovf;
   logic [1:0]      ser_i;
   logic [1:0]      ser_r;
   logic [1:0]      ser_y;
   logic [1:0]      busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(negedge clk) cyc <= cyc + 1;

   logic [8:0] exp_q0[$];
   logic [8:0] exp_q1[$];
   int         last_acc [2];
   int         prev_acc [2];
   logic       no_ser_chk = 1'b0;
   logic [1:0] rnd_or = 2'b00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
   endtask

   // Reference: {ovf, result}, from plain arithmetic
   function automatic logic [8:0] model(input logic [7:0] x);
      int         v;
      logic [7:0] y;
      v = (256 - int'(x)) % 256;
      y = v[7:0];
`ifdef TC_SERIAL_ABS_EN
      if (x < 8'h80) y = x;
`endif
      return {(x == 8'h80), y};
   endfunction

   function automatic void push_exp(input int g, input logic [7:0] x);
      if (g == 0) exp_q0.push_back(model(x));
      else        exp_q1.push_back(model(x));
   endfunction

   function automatic logic [9:0] pop_exp(input int g);
      if (g == 0) begin
         if (exp_q0.size() == 0) return 10'h0;
         return {1'b1, exp_q0.pop_front()};
      end
      if (exp_q1.size() == 0) return 10'h0;
      return {1'b1, exp_q1.pop_front()};
   endfunction

   function automatic int qsize(input int g);
      return (g == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int YL = 2 * g;

      // Behavioural serial complementer: copy bits up to and including the
      // first 1, invert afterwards; ser_r marks the first bit of a word
      logic       seen = 1'b0;
      logic [1:0] dly  = 2'b00;
      logic       y_now;
      assign y_now = ser_r[g] ? ser_i[g] : (ser_i[g] ^ seen);
      always @(posedge clk) begin
         seen <= ser_r[g] ? ser_i[g] : (seen | ser_i[g]);
         dly  <= {dly[0], y_now};
      end
      assign ser_y[g] = (YL == 0) ? y_now : dly[1];

      tc_serial_ctrl #(.W(W), .Y_LAT(YL)) u_dut (
         .t_clk    (clk),
         .r        (rst),
         .in_valid (in_valid[g]),
         .in_ready (in_ready[g]),
         .in_data  (in_data[g]),
         .out_valid(out_valid[g]),
         .out_ready(out_ready[g]),
         .out_data (out_data[g]),
         .out_ovf  (out_ovf[g]),
         .ser_i    (ser_i[g]),
         .ser_r    (ser_r[g]),
         .ser_y    (ser_y[g]),
         .busy     (busy[g])
      );

      // Output monitor: latency, scoreboard pop, hold-while-stalled
      int         acc_q[$];
      logic       prev_ov    = 1'b0;
      logic       stall_prev = 1'b0;
      logic [8:0] stall_val  = '0;
      logic [9:0] e;
      always @(negedge clk) begin
         if (rst) begin
            acc_q.delete();
            prev_ov    = 1'b0;
            stall_prev = 1'b0;
         end else begin
            if (in_valid[g] && in_ready[g]) begin
               acc_q.push_back(cyc);
               prev_acc[g] = last_acc[g];
               last_acc[g] = cyc;
            end
            if (out_valid[g] && !prev_ov) begin
               if (acc_q.size() == 0) fail($sformatf("orphan_out_valid[%0d]", g));
               else chk($sformatf("latency[%0d]", g), cyc - acc_q.pop_front(), 1 + W + YL);
            end
            if (stall_prev)
               chk($sformatf("hold[%0d]", g), {out_valid[g], out_ovf[g], out_data[g]}, {1'b1, stall_val});
            if (out_valid[g] && out_ready[g]) begin
               e = pop_exp(g);
               if (!e[9]) fail($sformatf("scoreboard_empty[%0d]", g));
               else chk($sformatf("result[%0d]", g), {out_ovf[g], out_data[g]}, e[8:0]);
            end
            stall_prev = out_valid[g] && !out_ready[g];
            stall_val  = {out_ovf[g], out_data[g]};
            prev_ov    = out_valid[g];
         end
      end

      // Serial monitor: bit order, first-bit reset marker, in_ready low while shifting
      logic [7:0] d;
      initial begin
         forever begin
            @(negedge clk);
            if (!rst && in_valid[g] && in_ready[g]) begin
               d = in_data[g];
               for (int k = 0; k < W; k++) begin
                  @(negedge clk);
                  if (rst || no_ser_chk) break;
                  chk($sformatf("ser_i[%0d] k=%0d", g, k), ser_i[g], d[k]);
                  chk($sformatf("ser_r[%0d] k=%0d", g, k), ser_r[g], (k == 0));
                  chk($sformatf("shift_in_ready_busy[%0d] k=%0d", g, k), {in_ready[g], busy[g]}, 2'b01);
               end
            end
         end
      end

      always @(negedge clk) begin
         if (rnd_or[g]) out_ready[g] = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input int g, input logic [7:0] x, input bit hold, input bit push);
      int n;
      @(negedge clk);
      in_valid[g] = 1'b1;
      in_data[g]  = x;
      n = 0;
      while (!in_ready[g] && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) fail($sformatf("accept_timeout[%0d]", g));
      else if (push) push_exp(g, x);
      @(posedge clk);
      #1;
      if (!hold) in_valid[g] = 1'b0;
   endtask

   task automatic drain(input int g);
      int n;
      n = 0;
      while ((qsize(g) != 0 || out_valid[g]) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) fail($sformatf("drain_timeout[%0d]", g));
   endtask

   task automatic chk_idle(input string name, input int g);
      chk(name, {in_ready[g], out_valid[g], out_data[g], out_ovf[g], ser_i[g], ser_r[g], busy[g]},
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
   endtask

   task automatic random_words(input int g, input int count);
      logic [7:0] x;
      rnd_or[g] = 1'b1;
      for (int i = 0; i < count; i++) begin
         case ($urandom_range(0, 7))
            0:       x = 8'h80;
            1:       x = 8'h00;
            2:       x = 8'hFF;
            3:       x = 8'h7F;
            default: x = 8'($urandom_range(0, 255));
         endcase
         send(g, x, 1'b0, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rnd_or[g] = 1'b0;
      @(negedge clk);
      out_ready[g] = 1'b1;
      drain(g);
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = '0;
      last_acc  = '{0, 0};
      prev_acc  = '{0, 0};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle("reset_state[0]", 0);
      chk_idle("reset_state[1]", 1);
      rst = 1'b0;

      // Single word, Y_LAT=0
      out_ready[0] = 1'b1;
      send(0, 8'h05, 1'b0, 1'b1);
      drain(0);

      // Back-to-back with in_valid held: minimum period W+2
      send(0, 8'h00, 1'b1, 1'b1);
      send(0, 8'h80, 1'b0, 1'b1);
      chk("b2b_period[0]", last_acc[0] - prev_acc[0], W + 2);
      drain(0);

      // Consumer stall: result held, no accept of the waiting word
      out_ready[0] = 1'b0;
      send(0, 8'h05, 1'b0, 1'b1);
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_data[0]  = 8'h01;
      n = 0;
      while (!out_valid[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail("stall_wait_out_valid");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_data", {out_valid[0], out_data[0]}, {1'b1, model(8'h05)[7:0]});
         chk("stall_no_accept", in_ready[0], 1'b0);
      end
      out_ready[0] = 1'b1;
      send(0, 8'h01, 1'b0, 1'b1);
      drain(0);

      // Reset during SHIFT bit 4 aborts the word
      no_ser_chk = 1'b1;
      send(0, 8'h7F, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_idle("abort_reset_state", 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      no_ser_chk = 1'b0;
      send(0, 8'h02, 1'b0, 1'b1);
      drain(0);

      random_words(0, 25);

      // Y_LAT=2 instance
      out_ready[1] = 1'b1;
      send(1, 8'h3C, 1'b0, 1'b1);
      drain(1);
      send(1, 8'h80, 1'b1, 1'b1);
      send(1, 8'h05, 1'b0, 1'b1);
      chk("b2b_period[1]", last_acc[1] - prev_acc[1], W + 2 + 2);
      drain(1);
      random_words(1, 25);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tc_serial_ctrl.md
Name: tc_serial_ctrl

Overview:
- Sequencing controller for the bit-serial two's-complement unit (serial input, serial output, active-high synchronous reset).
- Accepts a parallel W-bit word over a valid/ready handshake and pulses the unit's reset with the LSB.
- Streams the word into the unit LSB-first, reassembles the returned serial bits into a parallel result, and presents it over a second valid/ready handshake.
- Sits between parallel producers/consumers and the serial complementer; one word in flight at a time.

Parameters:
- W, 8, word width in bits (>=2).
- Y_LAT, 0, cycles from driving ser_i to the matching bit on ser_y (0 = combinational path through the unit).

Ports:
- t_clk  in  1  clock, all logic on rising edge
- r  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  controller can accept a word
- in_data  in  W  word to negate (two's complement)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  W  result word
- out_ovf  out  1  input was most-negative value (1 followed by W-1 zeros); result equals input
- ser_i  out  1  serial bit to unit, LSB first
- ser_r  out  1  reset to unit
- ser_y  in  1  serial result bit from unit
- busy  out  1  high in SHIFT or DRAIN

Behaviour:
- Reset (r=1 at an edge): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0, ser_i=0, ser_r=1, busy=0, counters cleared.
- Reset mid-operation aborts the word; no result is produced.
- States:
  - IDLE: in_ready=1, ser_r=1, ser_i=0. On in_valid&&in_ready: capture in_data into shift register sreg and compute ovf from it, clear bit counter k, go to SHIFT.
  - SHIFT: lasts W cycles, k=0..W-1. ser_i=sreg[k]. ser_r=1 only at k=0 (unit treats that bit as the first bit), 0 otherwise. in_ready=0.
    - After k=W-1: go to DRAIN if Y_LAT>0, else to DONE.
  - DRAIN: Y_LAT cycles. ser_r=0, ser_i=0.
  - DONE: out_valid=1; out_data and out_ovf stable. ser_r=1. On out_ready: out_valid=0 next cycle, go to IDLE.
- Capture: bit j of the result is sampled from ser_y at the rising edge ending cycle (SHIFT start + j + Y_LAT), into result register position j.
  - Sample window is tracked by a second counter delayed Y_LAT cycles from k, so sampling spans SHIFT and DRAIN.
- Latency: accept edge to out_valid high = 1 + W + Y_LAT cycles. Minimum word period = W + Y_LAT + 2 cycles when out_ready is held high.
- in_ready is combinationally equal to (state==IDLE). No accept is possible in the cycle out_valid drops.
- out_valid asserted with out_ready low: result held indefinitely; no new word is accepted.
- Arithmetic: out_data = (~in_data + 1) mod 2^W, as produced by the unit; the controller does not correct it.
  - out_ovf=1 iff in_data == {1, W-1 zeros}.
  - Input 0 gives output 0, out_ovf=0.
- Unused ser_y values outside the sample window are ignored.

Optional Feature:
- Macro: TC_SERIAL_ABS_EN.
- Defined:
  - Block computes absolute value.
  - If in_data[W-1]==0, the word is still streamed (constant timing) but out_data = captured in_data.
  - If in_data[W-1]==1, out_data = unit result.
  - out_ovf is unchanged (0x80 -> 0x80, ovf=1 for W=8).
- Not defined: every word is negated, as in Behaviour. Ports are identical in both builds.

Test Plan:
- Reset held 2 cycles, then W=8, Y_LAT=0, in_data=0x05, out_ready=1 -> ser_i sequence 1,0,1,0,0,0,0,0 with ser_r=1 only on the first bit; out_valid at accept+9 cycles; out_data=0xFB, out_ovf=0.
- in_data=0x00 then 0x80 back-to-back, in_valid held -> results 0x00 (ovf=0) and 0x80 (ovf=1); second accept occurs exactly 2 cycles after the first out_valid; in_ready low throughout SHIFT.
- Y_LAT=2 with a 2-stage delay model on ser_y, in_data=0x3C -> out_valid at accept+11 cycles, out_data=0xC4.
- out_ready low for 5 cycles after out_valid, in_valid high with 0x01 -> out_data holds 0xFB-style prior result stable, no accept; then release -> 0x01 yields 0xFF.
- Assert r at SHIFT bit 4 of in_data=0x7F -> next cycle IDLE, out_valid=0, ser_r=1; the following word 0x02 returns 0xFE.
- With TC_SERIAL_ABS_EN: inputs 0x05, 0xFB, 0x80 -> outputs 0x05, 0x05, 0x80 (ovf=1 on the last only); same latency as the non-ABS build.
